au_prefix_and_stream: RTL and testbench

AU_PREFIX_AND_STREAM -- requirements
Module: AU_prefix_and_stream

---
 rtl/au_prefix_and_stream.sv | 180 ++++++++++++++++++
 tb/tb_au_prefix_and_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_prefix_and_stream.sv
// au_prefix_and_stream
// Streaming prefix-AND over framed beats. Each accepted beat produces a
// registered running AND (bit 0 scanned first), seeded by a carry that
// links the beats of one frame. The output is a one-deep valid/ready stage
// with a latency of one cycle. ARCH selects the prefix network:
// 0 = ripple, 1 = Kogge-Stone, 2 = Sklansky. All three are functionally
// identical.
module au_prefix_and_stream #(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_all,
   output logic [CNTW-1:0]  out_idx
);

   localparam int              LEVELS  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNTW-1:0] IDX_MAX = '1;

   typedef enum logic {
      IDLE,
      INFRAME
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             carry;        // AND of every bit of the frame so far
   logic [CNTW-1:0]  idx_cnt;      // index the next beat of the open frame gets
   logic             accept;       // input transfer this cycle
   logic             frame_open;   // a partial frame is in progress
   logic             carry_eff;    // seed for the beat being accepted
   logic [CNTW-1:0]  idx_eff;      // index of the beat being accepted
   logic [CNTW-1:0]  idx_inc;      // saturating successor of idx_eff
   logic [WIDTH-1:0] prefix_raw;   // prefix AND of in_data alone
   logic [WIDTH-1:0] prefix_beat;  // prefix AND including the carry

   // The output stage is the only storage, so it can take a beat whenever
   // it is empty or being emptied in the same cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Prefix-AND network over in_data
   // ------------------------------------------------------------------
   if (ARCH == 1) begin : g_kogge_stone
      // Kogge-Stone: every bit combines with the bit 2^lvl below it.
      always_comb begin
         logic [WIDTH-1:0] cur;
         logic [WIDTH-1:0] nxt;
         cur = in_data;
         nxt = in_data;
         for (int lvl = 0; lvl < LEVELS; lvl++) begin
            nxt = cur;
            for (int i = 0; i < WIDTH; i++) begin
               if (i >= (1 << lvl)) begin
                  nxt[i] = cur[i] & cur[i - (1 << lvl)];
               end
            end
            cur = nxt;
         end
         prefix_raw = cur;
      end
   end else if (ARCH == 2) begin : g_sklansky
      // Sklansky: upper half of each 2^(lvl+1) group takes the top bit of
      // the lower half.
      always_comb begin
         logic [WIDTH-1:0] cur;
         logic [WIDTH-1:0] nxt;
         cur = in_data;
         nxt = in_data;
         for (int lvl = 0; lvl < LEVELS; lvl++) begin
            nxt = cur;
            for (int i = 0; i < WIDTH; i++) begin
               if (((i >> lvl) & 1) == 1) begin
                  nxt[i] = cur[i] & cur[((i >> lvl) << lvl) - 1];
               end
            end
            cur = nxt;
         end
         prefix_raw = cur;
      end
   end else begin : g_ripple
      // Ripple: a single AND chain from bit 0 upward.
      always_comb begin
         logic run;
         // NOTE: every combinational output gets a default before any
         // conditional logic, so no path leaves it unassigned (no latch).
         prefix_raw = '0;
         run        = 1'b1;
         for (int i = 0; i < WIDTH; i++) begin
            run           = run & in_data[i];
            prefix_raw[i] = run;
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of process order.
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: a beat without in_last opens a frame, in_last closes it.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = in_last ? IDLE : INFRAME;
      end
   end

   // FSM outputs: outside a frame the seed is always carry 1 and index 0.
   always_comb begin
      frame_open = (state == INFRAME);
      carry_eff  = frame_open ? carry : 1'b1;
      idx_eff    = frame_open ? idx_cnt : '0;
   end

   assign prefix_beat = prefix_raw & {WIDTH{carry_eff}};
   assign idx_inc     = (idx_eff == IDX_MAX) ? idx_eff : idx_eff + 1'b1;

   // ------------------------------------------------------------------
   // Frame context and output stage
   // ------------------------------------------------------------------

   // Carry and beat counter advance on every accepted beat; in_last rearms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry   <= 1'b1;
         idx_cnt <= '0;
      end else if (accept) begin
         if (in_last) begin
            carry   <= 1'b1;
            idx_cnt <= '0;
         end else begin
            carry   <= prefix_beat[WIDTH-1];
            idx_cnt <= idx_inc;
         end
      end
   end

   // Output register: load on accept, drain on output transfer, else hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_all   <= 1'b0;
         out_idx   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= prefix_beat;
         out_last  <= in_last;
         out_all   <= prefix_beat[WIDTH-1];
         out_idx   <= idx_eff;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_au_prefix_and_stream.sv
// tb_au_prefix_and_stream
// Self-checking bench: a software per-bit model pushes the expected output
// beat into a queue whenever an input transfer happens, and the queue is
// popped and compared on every output transfer. Directed scenarios add
// their own explicit checks.
module tb_au_prefix_and_stream;

   localparam int W  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          out_all;
   logic [CW-1:0] out_idx;

   typedef struct {
      logic [W-1:0]  data;
      logic          last;
      logic          all;
      logic [CW-1:0] idx;
   } exp_t;

   exp_t          sb[$];
   int            errors = 0;
   int            checks = 0;
   logic          m_carry;
   logic [CW-1:0] m_idx;

   always #5 clk = ~clk;

   au_prefix_and_stream #(
      .WIDTH (W),
      .ARCH  (0),
      .CNTW  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_all   (out_all),
      .out_idx   (out_idx)
   );

   // Per-bit reference model: compute the expected beat and queue it.
   task automatic model_push(input logic [W-1:0] d, input logic last);
      exp_t e;
      logic run;
      run = m_carry;
      for (int i = 0; i < W; i++) begin
         run       = run & d[i];
         e.data[i] = run;
      end
      e.last = last;
      e.all  = e.data[W-1];
      e.idx  = m_idx;
      sb.push_back(e);
      if (last) begin
         m_carry = 1'b1;
         m_idx   = '0;
      end else begin
         m_carry = e.data[W-1];
         if (m_idx != {CW{1'b1}}) m_idx = m_idx + 1'b1;
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_carry = 1'b1;
      m_idx   = '0;
   endtask

   // One clock cycle: sample at the falling edge, score transfers, advance.
   task automatic tick(output logic acc);
      exp_t e;
      logic otx;
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
         errors++;
         $display("FAIL in_ready_rule: got %b expected %b (out_valid=%b out_ready=%b)",
                  in_ready, (!out_valid || out_ready), out_valid, out_ready);
      end
      acc = in_valid && in_ready;
      otx = out_valid && out_ready;
      if (otx) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_beat: got data=%h idx=%0d expected no beat", out_data, out_idx);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.data || out_last !== e.last || out_all !== e.all || out_idx !== e.idx) begin
               errors++;
               $display("FAIL sb_beat: got data=%h last=%b all=%b idx=%0d expected data=%h last=%b all=%b idx=%0d",
                        out_data, out_last, out_all, out_idx, e.data, e.last, e.all, e.idx);
            end
         end
      end
      if (acc) model_push(in_data, in_last);
      @(posedge clk);
      #1;
   endtask

   // Present a beat and hold it until accepted (bounded).
   task automatic send(input logic [W-1:0] d, input logic last);
      logic acc;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int n = 0; n < 50; n++) begin
         tick(acc);
         if (acc) return;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept in 50 cycles expected accept of data=%h", d);
   endtask

   task automatic idle(input int n);
      logic acc;
      in_valid = 1'b0;
      repeat (n) tick(acc);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
      checks++;
      if (out_data !== '0 || out_last !== 1'b0 || out_all !== 1'b0 || out_idx !== '0) begin
         errors++;
         $display("FAIL reset_payload: got data=%h last=%b all=%b idx=%0d expected all zero",
                  out_data, out_last, out_all, out_idx);
      end
      rst = 1'b0;
      idle(3);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL idle_after_reset: got out_valid=%b in_ready=%b data=%h expected 0 1 00",
                  out_valid, in_ready, out_data);
      end
   endtask

   task automatic test_single_beat();
      out_ready = 1'b1;
      send(8'h0F, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0F || out_last !== 1'b1 || out_all !== 1'b0 || out_idx !== 8'd0) begin
         errors++;
         $display("FAIL single_0f: got v=%b data=%h last=%b all=%b idx=%0d expected 1 0f 1 0 0",
                  out_valid, out_data, out_last, out_all, out_idx);
      end
      send(8'hFF, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF || out_all !== 1'b1 || out_idx !== 8'd0) begin
         errors++;
         $display("FAIL single_ff: got v=%b data=%h all=%b idx=%0d expected 1 ff 1 0",
                  out_valid, out_data, out_all, out_idx);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send(8'hFF, 1'b0);
      checks++;
      if (out_data !== 8'hFF || out_idx !== 8'd0 || out_all !== 1'b1 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL b2b_beat0: got data=%h idx=%0d all=%b last=%b expected ff 0 1 0",
                  out_data, out_idx, out_all, out_last);
      end
      send(8'hF7, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h07 || out_idx !== 8'd1 || out_all !== 1'b0 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL b2b_beat1: got v=%b data=%h idx=%0d all=%b last=%b expected 1 07 1 0 1",
                  out_valid, out_data, out_idx, out_all, out_last);
      end
      send(8'hFF, 1'b1);
      checks++;
      if (out_data !== 8'hFF || out_idx !== 8'd0 || out_all !== 1'b1) begin
         errors++;
         $display("FAIL b2b_carry_restored: got data=%h idx=%0d all=%b expected ff 0 1",
                  out_data, out_idx, out_all);
      end
      idle(2);
   endtask

   task automatic test_carry_kill();
      logic [W-1:0] beats [3];
      beats[0] = 8'hFE;
      beats[1] = 8'hFF;
      beats[2] = 8'hFF;
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         send(beats[b], (b == 2));
         checks++;
         if (out_data !== 8'h00 || out_all !== 1'b0 || out_idx !== CW'(b)) begin
            errors++;
            $display("FAIL carry_kill_beat%0d: got data=%h all=%b idx=%0d expected 00 0 %0d",
                     b, out_data, out_all, out_idx, b);
         end
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      logic acc;
      out_ready = 1'b1;
      send(8'h3F, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      in_last   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(acc);
         checks++;
         if (acc !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h3F ||
             out_idx !== 8'd0 || out_last !== 1'b0 || out_all !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold%0d: got acc=%b rdy=%b v=%b data=%h idx=%0d last=%b all=%b expected 0 0 1 3f 0 0 0",
                     c, acc, in_ready, out_valid, out_data, out_idx, out_last, out_all);
         end
      end
      out_ready = 1'b1;
      send(8'h01, 1'b1);
      checks++;
      if (out_data !== 8'h00 || out_idx !== 8'd1 || out_last !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_next: got data=%h idx=%0d last=%b expected 00 1 1",
                  out_data, out_idx, out_last);
      end
      idle(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL backpressure_drain: got %0d pending beats expected 0", sb.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      logic acc;
      out_ready = 1'b0;
      send(8'h7F, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 8'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_clear: got v=%b data=%h idx=%0d rdy=%b expected 0 00 0 1",
                  out_valid, out_data, out_idx, in_ready);
      end
      model_reset();
      tick(acc);
      rst       = 1'b0;
      out_ready = 1'b1;
      send(8'hFF, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF || out_idx !== 8'd0 || out_all !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_new_frame: got v=%b data=%h idx=%0d all=%b expected 1 ff 0 1",
                  out_valid, out_data, out_idx, out_all);
      end
      idle(2);
   endtask

   task automatic test_idx_saturate();
      out_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         send(8'hFF, (n == 299));
         if (n == 255 || n == 299) begin
            checks++;
            if (out_idx !== 8'd255 || out_data !== 8'hFF) begin
               errors++;
               $display("FAIL idx_saturate_beat%0d: got idx=%0d data=%h expected 255 ff",
                        n, out_idx, out_data);
            end
         end
      end
      send(8'hFF, 1'b1);
      checks++;
      if (out_idx !== 8'd0) begin
         errors++;
         $display("FAIL idx_after_saturate: got idx=%0d expected 0", out_idx);
      end
      idle(2);
   endtask

   task automatic test_random();
      logic         acc;
      logic [W-1:0] d;
      int           accepted = 0;
      int           cycles   = 0;
      while (accepted < 10000 && cycles < 60000) begin
         case ($urandom_range(0, 3))
            0:       d = W'($urandom);
            1:       d = '1;
            2:       d = ~(W'(1) << $urandom_range(0, W - 1));
            default: d = W'((1 << $urandom_range(0, W)) - 1);
         endcase
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = d;
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick(acc);
         if (acc) accepted++;
         cycles++;
      end
      checks++;
      if (accepted != 10000) begin
         errors++;
         $display("FAIL random_progress: got %0d beats in %0d cycles expected 10000", accepted, cycles);
      end
      out_ready = 1'b1;
      idle(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL random_drain: got %0d pending beats expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_carry_kill();
      test_backpressure();
      test_reset_mid_frame();
      test_idx_saturate();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
